// File: rtl/span_pixel_walker_if.sv
// Stream bundle for span_pixel_walker: span input stream and pixel output stream.
// The walker connects through the slave modport; the producer/consumer side
// uses master.
interface span_pixel_walker_if;
  // span input stream
  logic        span_valid;
  logic        span_ready;
  logic [31:0] span_mask;
  logic [10:0] span_x;
  logic [10:0] span_y;
  // pixel output stream
  logic        pix_valid;
  logic        pix_ready;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        pix_last;

  modport slave (
    input  span_valid, span_mask, span_x, span_y, pix_ready,
    output span_ready, pix_valid, pix_x, pix_y, pix_last
  );

  modport master (
    output span_valid, span_mask, span_x, span_y, pix_ready,
    input  span_ready, pix_valid, pix_x, pix_y, pix_last
  );
endinterface

// File: rtl/span_pixel_walker.sv
// span_pixel_walker: serialises a 32-pixel coverage span into one covered
// pixel per cycle, lowest tile column first. The work mask itself is the
// state: non-zero means walking, zero means idle and ready for a new span.
module span_pixel_walker (
  input  logic                    clock,
  input  logic                    reset,
  span_pixel_walker_if.slave      bus,
  output logic [31:0]             pix_count,
  output logic [15:0]             span_count
);

  logic [31:0] r_cur_mask;
  logic [5:0]  r_cur_xb;
  logic [10:0] r_cur_y;
  logic        r_pix_valid;
  logic [10:0] r_pix_x;
  logic [10:0] r_pix_y;
  logic        r_pix_last;
  logic [31:0] r_pix_count;
  logic [15:0] r_span_count;

  logic [31:0] w_mask_rest;
  logic [4:0]  w_idx;
  logic        w_out_free;
  logic        w_extract;
  logic        w_span_ready;
  logic        w_accept;
  logic        w_unused_xlo;

  // The low tile-column bits of span_x are defined as zero, so they are dropped.
  assign w_unused_xlo = ^bus.span_x[4:0];

  // Mask with its lowest set bit removed; zero means one pixel (or none) remains.
  assign w_mask_rest  = r_cur_mask & (r_cur_mask - 32'd1);
  assign w_out_free   = !r_pix_valid || bus.pix_ready;
  assign w_extract    = (r_cur_mask != 32'd0) && w_out_free;
  // A new span may enter while idle, or in the cycle the final pixel leaves the mask.
  assign w_span_ready = (r_cur_mask == 32'd0) || (w_out_free && (w_mask_rest == 32'd0));
  assign w_accept     = bus.span_valid && w_span_ready;

  // Priority encoder: index of the lowest set bit of the work mask.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_idx unassigned (no latch).
    w_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (r_cur_mask[i]) w_idx = 5'(i);
    end
  end

  // Work registers, output pixel register and counters.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_cur_mask   <= '0;
      r_cur_xb     <= '0;
      r_cur_y      <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_last   <= 1'b0;
      r_pix_count  <= '0;
      r_span_count <= '0;
    end else begin
      // Output register: load a fresh pixel, drain, or hold while stalled.
      if (w_extract) begin
        r_pix_valid <= 1'b1;
        r_pix_x     <= {r_cur_xb, w_idx};
        r_pix_y     <= r_cur_y;
        r_pix_last  <= (w_mask_rest == 32'd0);
      end else if (w_out_free) begin
        r_pix_valid <= 1'b0;
      end

      // A new span overwrites the work registers; only possible once the old
      // span's final pixel is being extracted this same cycle.
      if (w_accept) begin
        r_cur_mask   <= bus.span_mask;
        r_cur_xb     <= bus.span_x[10:5];
        r_cur_y      <= bus.span_y;
        r_span_count <= r_span_count + 16'd1;
      end else if (w_extract) begin
        r_cur_mask   <= w_mask_rest;
      end

      if (r_pix_valid && bus.pix_ready) begin
        r_pix_count <= r_pix_count + 32'd1;
      end
    end
  end

  assign bus.span_ready = w_span_ready;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_x      = r_pix_x;
  assign bus.pix_y      = r_pix_y;
  assign bus.pix_last   = r_pix_last;
  assign pix_count      = r_pix_count;
  assign span_count     = r_span_count;

endmodule

// File: tb/tb_span_pixel_walker.sv
// Testbench for span_pixel_walker: directed scenarios plus a randomized run
// checked against a pixel-list scoreboard built from each accepted span.
module tb_span_pixel_walker;

  logic        clock;
  logic        reset;
  logic [31:0] pix_count;
  logic [15:0] span_count;

  span_pixel_walker_if bus ();

  span_pixel_walker dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .pix_count  (pix_count),
    .span_count (span_count)
  );

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        last;
  } pix_t;

  pix_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: every accepted span expands into its covered pixels in
  // ascending column order; every handed-off pixel must match the queue head.
  always @(posedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.span_valid && bus.span_ready) begin
        for (int i = 0; i < 32; i++) begin
          if (bus.span_mask[i]) begin
            pix_t p;
            p.x    = {bus.span_x[10:5], 5'(i)};
            p.y    = bus.span_y;
            p.last = ((bus.span_mask >> (i + 1)) == 32'd0);
            exp_q.push_back(p);
          end
        end
      end
      if (bus.pix_valid && bus.pix_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_pixel got x=%h y=%h last=%b expected no pixel",
                   bus.pix_x, bus.pix_y, bus.pix_last);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          if (bus.pix_x !== e.x || bus.pix_y !== e.y || bus.pix_last !== e.last) begin
            tests_failed++;
            $display("FAIL sb_pixel got x=%h y=%h last=%b expected x=%h y=%h last=%b",
                     bus.pix_x, bus.pix_y, bus.pix_last, e.x, e.y, e.last);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.span_valid = 1'b0;
    bus.span_mask  = '0;
    bus.span_x     = '0;
    bus.span_y     = '0;
    bus.pix_ready  = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.pix_valid !== 1'b0 || bus.pix_x !== 11'd0 || bus.pix_y !== 11'd0 ||
        bus.pix_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got v=%b x=%h y=%h last=%b expected 0 0 0 0",
               bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_last);
    end
    tests_run++;
    if (pix_count !== 32'd0 || span_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_counters got pix=%0d span=%0d expected 0 0", pix_count, span_count);
    end
    tests_run++;
    if (bus.span_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_span_ready got %b expected 1", bus.span_ready);
    end
  endtask

  task automatic expect_pix(input string name, input logic v, input logic [10:0] x,
                            input logic [10:0] y, input logic last);
    tests_run++;
    if (bus.pix_valid !== v || (v && (bus.pix_x !== x || bus.pix_y !== y || bus.pix_last !== last))) begin
      tests_failed++;
      $display("FAIL %s got v=%b x=%h y=%h last=%b expected v=%b x=%h y=%h last=%b",
               name, bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_last, v, x, y, last);
    end
  endtask

  task automatic test_basic();
    do_reset();
    bus.pix_ready  = 1'b1;
    bus.span_valid = 1'b1;
    bus.span_mask  = 32'h8000_0011;
    bus.span_x     = 11'h065;
    bus.span_y     = 11'd7;
    tests_run++;
    if (bus.span_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_ready got %b expected 1", bus.span_ready);
    end
    tick();                     // accept edge
    bus.span_valid = 1'b0;
    expect_pix("basic_latency", 1'b0, 11'h000, 11'd0, 1'b0);
    tick();
    expect_pix("basic_pix0", 1'b1, 11'h060, 11'd7, 1'b0);
    tick();
    expect_pix("basic_pix1", 1'b1, 11'h064, 11'd7, 1'b0);
    tick();
    expect_pix("basic_pix2", 1'b1, 11'h07F, 11'd7, 1'b1);
    tick();
    expect_pix("basic_drained", 1'b0, 11'h000, 11'd0, 1'b0);
    tests_run++;
    if (pix_count !== 32'd3 || span_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL basic_counts got pix=%0d span=%0d expected 3 1", pix_count, span_count);
    end
  endtask

  task automatic test_empty_span();
    do_reset();
    bus.pix_ready  = 1'b1;
    bus.span_valid = 1'b1;
    bus.span_mask  = 32'h0;
    bus.span_x     = 11'h100;
    bus.span_y     = 11'd3;
    tests_run++;
    if (bus.span_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_ready0 got %b expected 1", bus.span_ready);
    end
    tick();
    bus.span_mask = 32'h2;
    bus.span_x    = 11'h120;
    bus.span_y    = 11'd4;
    tests_run++;
    if (bus.span_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_ready1 got %b expected 1", bus.span_ready);
    end
    tick();
    bus.span_valid = 1'b0;
    tick();
    expect_pix("empty_single_pix", 1'b1, 11'h121, 11'd4, 1'b1);
    tests_run++;
    if (bus.span_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_bit_ready got %b expected 1", bus.span_ready);
    end
    repeat (2) tick();
    tests_run++;
    if (pix_count !== 32'd1 || span_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL empty_counts got pix=%0d span=%0d expected 1 2", pix_count, span_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] xs[40];
    logic [10:0] ys[40];
    logic        ls[40];
    int          cyc[40];
    int          n     = 0;
    int          sent  = 0;
    logic        acc;
    do_reset();
    bus.pix_ready  = 1'b1;
    bus.span_valid = 1'b1;
    bus.span_mask  = 32'hFFFF_FFFF;
    bus.span_x     = 11'h200;
    bus.span_y     = 11'd9;
    for (int c = 0; c < 60; c++) begin
      acc = bus.span_valid && bus.span_ready;
      if (bus.pix_valid && n < 40) begin
        xs[n] = bus.pix_x; ys[n] = bus.pix_y; ls[n] = bus.pix_last; cyc[n] = c;
        n++;
      end
      tick();
      if (acc) begin
        sent++;
        if (sent == 1) begin
          bus.span_mask = 32'h0000_0003;
          bus.span_x    = 11'h3E0;
          bus.span_y    = 11'd10;
        end else begin
          bus.span_valid = 1'b0;
        end
      end
    end
    tests_run++;
    if (n != 34) begin
      tests_failed++;
      $display("FAIL b2b_pixel_total got %0d expected 34", n);
    end else begin
      tests_run++;
      if (cyc[33] - cyc[0] != 33) begin
        tests_failed++;
        $display("FAIL b2b_bubble got span of %0d cycles expected 33", cyc[33] - cyc[0]);
      end
      for (int k = 0; k < 34; k++) begin
        logic [10:0] ex;
        logic [10:0] ey;
        ex = (k < 32) ? 11'(11'h200 + k) : 11'(11'h3E0 + (k - 32));
        ey = (k < 32) ? 11'd9 : 11'd10;
        tests_run++;
        if (xs[k] !== ex || ys[k] !== ey || ls[k] !== (k == 31 || k == 33)) begin
          tests_failed++;
          $display("FAIL b2b_pix%0d got x=%h y=%h last=%b expected x=%h y=%h last=%b",
                   k, xs[k], ys[k], ls[k], ex, ey, (k == 31 || k == 33));
        end
      end
    end
  endtask

  task automatic test_stall();
    int          hs     = 0;
    int          remain;
    logic        held   = 1'b0;
    logic [10:0] held_x = '0;
    logic        held_l = 1'b0;
    logic        exp_ready;
    do_reset();
    bus.pix_ready  = 1'b1;
    bus.span_valid = 1'b1;
    bus.span_mask  = 32'h0000_00F0;
    bus.span_x     = 11'h040;
    bus.span_y     = 11'd1;
    tick();
    bus.span_valid = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bus.pix_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      remain    = 4 - hs - (bus.pix_valid ? 1 : 0);
      exp_ready = (remain == 0) || ((!bus.pix_valid || bus.pix_ready) && remain == 1);
      tests_run++;
      if (bus.span_ready !== exp_ready) begin
        tests_failed++;
        $display("FAIL stall_ready c=%0d got %b expected %b", c, bus.span_ready, exp_ready);
      end
      if (held) begin
        tests_run++;
        if (bus.pix_valid !== 1'b1 || bus.pix_x !== held_x || bus.pix_last !== held_l) begin
          tests_failed++;
          $display("FAIL stall_hold c=%0d got v=%b x=%h last=%b expected v=1 x=%h last=%b",
                   c, bus.pix_valid, bus.pix_x, bus.pix_last, held_x, held_l);
        end
      end
      if (bus.pix_valid && bus.pix_ready) begin
        tests_run++;
        if (bus.pix_x !== 11'(11'h044 + hs) || bus.pix_last !== (hs == 3)) begin
          tests_failed++;
          $display("FAIL stall_order n=%0d got x=%h last=%b expected x=%h last=%b",
                   hs, bus.pix_x, bus.pix_last, 11'(11'h044 + hs), (hs == 3));
        end
        hs++;
      end
      held   = bus.pix_valid && !bus.pix_ready;
      held_x = bus.pix_x;
      held_l = bus.pix_last;
      tick();
    end
    tests_run++;
    if (hs != 4) begin
      tests_failed++;
      $display("FAIL stall_count got %0d expected 4", hs);
    end
  endtask

  task automatic test_reset_mid();
    int n_pix = 0;
    do_reset();
    bus.pix_ready  = 1'b1;
    bus.span_valid = 1'b1;
    bus.span_mask  = 32'h0000_FFFF;
    bus.span_x     = 11'h000;
    bus.span_y     = 11'd2;
    tick();
    bus.span_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (bus.pix_valid !== 1'b0 || pix_count !== 32'd0 || span_count !== 16'd0 ||
        bus.span_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_state got v=%b pix=%0d span=%0d rdy=%b expected 0 0 0 1",
               bus.pix_valid, pix_count, span_count, bus.span_ready);
    end
    bus.span_valid = 1'b1;
    bus.span_mask  = 32'h1;
    bus.span_x     = 11'h020;
    bus.span_y     = 11'd3;
    tick();
    bus.span_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (bus.pix_valid) begin
        n_pix++;
        expect_pix("midreset_pix", 1'b1, 11'h020, 11'd3, 1'b1);
      end
      tick();
    end
    tests_run++;
    if (n_pix != 1 || pix_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL midreset_count got seen=%0d pix=%0d expected 1 1", n_pix, pix_count);
    end
  endtask

  function automatic logic [31:0] gen_mask();
    int mode = $urandom_range(0, 19);
    if (mode < 5)       return 32'h0;
    else if (mode < 10) return 32'h1 << $urandom_range(0, 31);
    else if (mode < 11) return 32'hFFFF_FFFF;
    else                return $urandom & $urandom & $urandom;
  endfunction

  task automatic test_random();
    int          accepted = 0;
    int          cycles   = 0;
    logic [31:0] total    = 0;
    logic        acc;
    do_reset();
    while (accepted < 10000 && cycles < 90000) begin
      bus.pix_ready = ($urandom_range(0, 9) < 8);
      if (!bus.span_valid && $urandom_range(0, 9) < 9) begin
        bus.span_valid = 1'b1;
        bus.span_mask  = gen_mask();
        bus.span_x     = 11'($urandom);
        bus.span_y     = 11'($urandom);
      end
      #1;
      acc = bus.span_valid && bus.span_ready;
      if (acc) begin
        accepted++;
        total = total + 32'($countones(bus.span_mask));
      end
      tick();
      cycles++;
      if (acc) bus.span_valid = 1'b0;
    end
    tests_run++;
    if (accepted != 10000) begin
      tests_failed++;
      $display("FAIL rand_timeout got %0d spans expected 10000", accepted);
    end
    bus.span_valid = 1'b0;
    bus.pix_ready  = 1'b1;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || bus.pix_valid); c++) tick();
    tests_run++;
    if (exp_q.size() != 0 || bus.pix_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rand_drain got %0d pending expected 0", exp_q.size());
    end
    tests_run++;
    if (pix_count !== total || span_count !== 16'(accepted)) begin
      tests_failed++;
      $display("FAIL rand_counts got pix=%0d span=%0d expected %0d %0d",
               pix_count, span_count, total, 16'(accepted));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_span();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
